// File: rtl/div_rate_pkg.sv
// div_rate_pkg: shared FSM states, mode encodings and limits for the rate divider
package div_rate_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BURST, ST_PEND} state_t;
  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/div_rate_ctrl_counter.sv
// div_counter: period register and 0..P-1 counter producing div_out and tick
module div_counter #(
  parameter int CNT_W = 8,
  parameter int DEFAULT_PERIOD = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_div,
  output logic             o_tick
);
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_period;
  logic             w_wrap;
  assign w_wrap = r_count == r_period - 1'b1;
  assign o_tick = i_en && w_wrap;
  assign o_div  = i_en && r_count >= (r_period >> 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_period <= CNT_W'(DEFAULT_PERIOD);
    end else begin
      if (i_load)
        r_period <= i_period;
      r_count <= (i_clear || !i_en || w_wrap) ? '0 : r_count + 1'b1;
    end
  end
endmodule

// File: rtl/div_rate_ctrl.sv
// div_rate_ctrl: programmable divider with FREE/BURST modes; reconfiguration waits for a period boundary
module div_rate_ctrl
  import div_rate_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DEFAULT_PERIOD = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [7:0]       cfg_burst,
  output logic             div_out,
  output logic             tick,
  output logic             busy,
  output logic             burst_done,
  output logic             err
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sh_mode;
  logic [CNT_W-1:0] r_sh_period;
  logic [7:0]       r_sh_burst;
  logic [7:0]       r_burst;
  logic [7:0]       w_burst_nxt;
  logic             r_err;
  logic             w_fire;
  logic             w_legal;
  logic             w_apply;
  logic             w_store;
  logic [1:0]       w_mode;
  logic [CNT_W-1:0] w_period;
  logic [7:0]       w_nburst;
  assign cfg_ready  = r_state != ST_PEND;
  assign busy       = r_state != ST_IDLE;
  assign err        = r_err;
  assign burst_done = tick && r_burst == 8'd1;
  assign w_fire     = cfg_valid && cfg_ready;
  assign w_legal    = cfg_mode != MODE_RSVD && cfg_period >= CNT_W'(MIN_PERIOD) &&
                      (cfg_mode != MODE_BURST || cfg_burst != 8'd0);
  div_counter #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DEFAULT_PERIOD)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (busy),
    .i_load  (w_apply && w_mode != MODE_STOP),
    .i_clear (w_apply),
    .i_period(w_period),
    .o_div   (div_out),
    .o_tick  (tick)
  );
  // An interrupted burst keeps counting down in PEND; its final tick is also the apply boundary
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = (tick && r_burst != 8'd0) ? r_burst - 8'd1 : r_burst;
    w_mode      = cfg_mode;
    w_period    = cfg_period;
    w_nburst    = cfg_burst;
    w_apply     = 1'b0;
    w_store     = 1'b0;
    if (w_fire && w_legal) begin
      w_apply     = r_state == ST_IDLE || tick;
      w_store     = !w_apply;
      w_state_nxt = w_apply ? r_state : ST_PEND;
    end else if (r_state == ST_PEND && tick) begin
      w_apply  = 1'b1;
      w_mode   = r_sh_mode;
      w_period = r_sh_period;
      w_nburst = r_sh_burst;
    end else if (burst_done) begin
      w_state_nxt = ST_IDLE;
    end
    if (w_apply) begin
      w_state_nxt = w_mode == MODE_FREE ? ST_RUN : w_mode == MODE_BURST ? ST_BURST : ST_IDLE;
      w_burst_nxt = w_mode == MODE_BURST ? w_nburst : 8'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_burst     <= '0;
      r_sh_mode   <= MODE_STOP;
      r_sh_period <= '0;
      r_sh_burst  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
      r_err   <= r_err | (w_fire & ~w_legal);
      if (w_store) begin
        r_sh_mode   <= cfg_mode;
        r_sh_period <= cfg_period;
        r_sh_burst  <= cfg_burst;
      end
    end
  end
endmodule

// File: tb/tb_div_rate_ctrl.sv
// tb_div_rate_ctrl: directed scenarios with a tick scoreboard keyed on cycle number
module tb_div_rate_ctrl;
  import div_rate_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_mode = 2'b00;
  logic [7:0] cfg_period = 8'd0;
  logic [7:0] cfg_burst = 8'd0;
  logic       cfg_ready, div_out, tick, busy, burst_done, err;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  typedef struct {int c; logic d;} ev_t;
  ev_t q[$];
  ev_t mon_e;
  div_rate_ctrl dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_burst(cfg_burst),
    .div_out(div_out), .tick(tick), .busy(busy), .burst_done(burst_done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask
  // Scoreboard: every tick must match the next expected cycle and burst_done flag
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].c < cyc) begin
      chk("missed_tick_cyc", cyc, q[0].c);
      void'(q.pop_front());
    end
    if (tick || burst_done) begin
      if (q.size() == 0) chk("unexpected_tick_cyc", cyc, 0);
      else begin
        mon_e = q.pop_front();
        chk("tick_cyc", cyc, mon_e.c);
        chk("tick", tick, 1);
        chk("burst_done", burst_done, mon_e.d);
      end
    end
  end
  task automatic exp_ticks(input int first, input int p, input int n, input bit last_done);
    for (int i = 0; i < n; i++) q.push_back('{c: first + i * p, d: last_done && i == n - 1});
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic cfg(input logic [1:0] m, input int p, input int b, output int h);
    cfg_valid  = 1'b1;
    cfg_mode   = m;
    cfg_period = p[7:0];
    cfg_burst  = b[7:0];
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    h = cyc;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_div"}, div_out, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_bdone"}, burst_done, 0);
    chk({tag, "_ready"}, cfg_ready, 1);
  endtask
  initial begin
    int h, h0;
    do_reset();
    chk_idle("rst");
    chk("rst_err", err, 0);
    // FREE P=24: 12 low, 12 high, tick on the last count
    cfg(MODE_FREE, 24, 0, h0);
    exp_ticks(h0 + 23, 24, 3, 1'b0);
    chk("free_busy", busy, 1);
    chk("free_div0", div_out, 0);
    wait_until(h0 + 24);
    for (int i = 0; i < 24; i++) begin
      chk("free_div_phase", div_out, i >= 12);
      @(posedge clk);
      #1;
    end
    wait_until(h0 + 72);
    do_reset();
    // BURST P=5 N=3
    cfg(MODE_BURST, 5, 3, h0);
    exp_ticks(h0 + 4, 5, 3, 1'b1);
    chk("burst_busy", busy, 1);
    wait_until(h0 + 15);
    chk_idle("burst_end");
    wait_until(h0 + 25);
    // RUN P=10, reconfigure to P=4 at count 3
    cfg(MODE_FREE, 10, 0, h0);
    exp_ticks(h0 + 9, 10, 1, 1'b0);
    exp_ticks(h0 + 13, 4, 3, 1'b0);
    wait_until(h0 + 3);
    cfg(MODE_FREE, 4, 0, h);
    chk("pend_ready_lo", cfg_ready, 0);
    chk("pend_busy", busy, 1);
    wait_until(h0 + 9);
    chk("pend_ready_at_tick", cfg_ready, 0);
    wait_until(h0 + 10);
    chk("pend_ready_hi", cfg_ready, 1);
    chk("new_div_c0", div_out, 0);
    wait_until(h0 + 12);
    chk("new_div_c2", div_out, 1);
    wait_until(h0 + 22);
    do_reset();
    // Write in the count = P-1 cycle takes effect immediately
    cfg(MODE_FREE, 6, 0, h0);
    exp_ticks(h0 + 5, 6, 1, 1'b0);
    exp_ticks(h0 + 8, 3, 3, 1'b0);
    wait_until(h0 + 5);
    cfg(MODE_FREE, 3, 0, h);
    for (int i = 0; i < 3; i++) begin
      chk("boundary_ready", cfg_ready, 1);
      @(posedge clk);
      #1;
    end
    wait_until(h0 + 15);
    do_reset();
    // Illegal configurations are discarded and set sticky err
    cfg(MODE_FREE, 8, 0, h0);
    exp_ticks(h0 + 7, 8, 3, 1'b0);
    chk("err_before", err, 0);
    wait_until(h0 + 2);
    cfg(MODE_FREE, 1, 0, h);
    chk("err_p1", err, 1);
    chk("err_p1_ready", cfg_ready, 1);
    cfg(MODE_RSVD, 8, 0, h);
    chk("err_mode3", err, 1);
    cfg(MODE_BURST, 8, 0, h);
    chk("err_n0", err, 1);
    chk("err_n0_busy", busy, 1);
    chk("err_n0_ready", cfg_ready, 1);
    wait_until(h0 + 24);
    chk("err_sticky", err, 1);
    do_reset();
    chk("err_cleared", err, 0);
    // Reset while PEND at count 7 leaves nothing behind
    cfg(MODE_FREE, 24, 0, h0);
    wait_until(h0 + 3);
    cfg(MODE_FREE, 12, 0, h);
    chk("pend_before_rst", cfg_ready, 0);
    wait_until(h0 + 7);
    do_reset();
    chk_idle("pend_rst");
    chk("pend_rst_err", err, 0);
    wait_until(h0 + 48);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
